mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage load/store engine sitting between the EX/ME pipeline register and the ME/WB register. It turns the ME-stage memory control bits into a request/acknowledge transaction on the data-memory port, stalls the pipeline while the transaction is outstanding, and formats the load data into the ME/WB register's memory-data input. Non-memory instructions pass through with zero added latency.

Parameters:
TIMEOUT, 16, max cycles in WAIT before bus error is flagged (range 2..255)

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous, active-low reset
me_valid  input  1  ME stage holds a real (non-bubble) instruction
me_memRead  input  1  instruction is a load
me_memWrite  input  1  instruction is a store
me_memSize  input  2  00 byte, 01 half, 10 word, 11 treated as word
me_memSigned  input  1  sign-extend loads (1) / zero-extend (0)
me_addr  input  32  effective address (ALU result)
me_storeData  input  32  unaligned store source (rt value)
me_writeRegIn  input  1  register write enable from EX/ME
dm_req  output  1  memory request, held until dm_ack
dm_we  output  1  request is a write
dm_addr  output  30  word address (me_addr[31:2])
dm_wdata  output  32  lane-replicated store data
dm_wstrb  output  4  byte write strobes
dm_ack  input  1  memory completion, single-cycle pulse
dm_rdata  input  32  read word, valid with dm_ack
me_outMem  output  32  formatted load data to ME/WB register
me_writeReg  output  1  gated register write enable to ME/WB register
stall  output  1  freeze PC, IF/ID, ID/EX, EX/ME; ME/WB inserts bubble
me_misalign  output  1  alignment fault for current instruction
me_busErr  output  1  transaction exceeded TIMEOUT

Behaviour:
- access = me_valid & (me_memRead | me_memWrite); aligned = byte, or half with addr[0]=0, or word with addr[1:0]=0.
- FSM states IDLE, WAIT, DONE. Reset (rst=0, async): state IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_wstrb=0, me_outMem=0, me_busErr=0, timeout counter 0. Asserting reset in WAIT abandons the transaction; a late dm_ack after reset release is ignored in IDLE.
- IDLE: access & aligned -> WAIT; register dm_req=1, dm_we=me_memWrite, dm_addr, dm_wdata, dm_wstrb; stall=1 this cycle (combinational). Otherwise stay IDLE, stall=0.
- WAIT: dm_req held, all dm_* outputs stable; stall=1; counter increments each cycle. dm_ack -> DONE, dm_req=0, counter cleared; for loads me_outMem <= formatted dm_rdata. Counter reaches TIMEOUT without ack -> DONE, dm_req=0, me_busErr=1, me_outMem=0.
- DONE: stall=0 (pipeline advances, ME/WB captures me_outMem); next cycle -> IDLE, me_busErr cleared. No new access is started from DONE even though access=1 (same instruction).
- Minimum cost of a memory op: 2 stall cycles (ack in first WAIT cycle).
- Store formatting: byte -> wdata={4{b}}, wstrb=0001<<addr[1:0]; half -> wdata={2{h}}, wstrb=0011<<addr[1:0]; word -> wdata as-is, wstrb=1111.
- Load formatting: select byte/half lane by addr[1:0], sign- or zero-extend per me_memSigned; word unchanged. Stores leave me_outMem unchanged.
- Misaligned access: no request, stall=0, me_misalign=1 (combinational), me_writeReg=0. Non-access: me_misalign=0.
- me_writeReg = me_writeRegIn & ~me_misalign & ~me_busErr-in-DONE; stores never modify it (decoder clears write for stores).
- dm_ack outside WAIT is ignored. me_memRead & me_memWrite both set: treated as store.

Test Plan:
- lw, addr 0x0000_0104, dm_ack on 1st WAIT cycle, rdata 0xDEADBEEF -> dm_req 1 cycle, dm_addr 0x41, stall 2 cycles, me_outMem 0xDEADBEEF in DONE.
- lb signed, addr 0x...03, rdata 0x80112233 -> me_outMem 0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x...02 signed, rdata 0x8001xxxx -> 0xFFFF8001.
- sb addr 0x...02, storeData 0x123456AB -> dm_we 1, dm_wdata 0xABABABAB, dm_wstrb 0100; sh addr 0x...02 data 0x0000BEEF -> wdata 0xBEEFBEEF, wstrb 1100.
- lw addr 0x...06 -> dm_req never asserted, stall 0, me_misalign 1, me_writeReg 0.
- TIMEOUT=4, no dm_ack -> dm_req high 4 cycles, DONE with me_busErr 1, me_outMem 0, stall releases; late ack ignored.
- rst low during WAIT -> dm_req 0 immediately, state IDLE, stall 0 when no access; ALU-only instruction back-to-back with loads -> zero stall cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: ME-stage load/store engine.
// Converts the ME-stage memory control bits into one request/acknowledge
// transaction on the data-memory port. It stalls the pipeline while that
// transaction is outstanding and formats load data for the ME/WB register.
//
// Memory handshake: dm_req rises with dm_we/dm_addr/dm_wdata/dm_wstrb already
// valid, and all of them stay frozen until the cycle in which dm_ack is sampled
// high. dm_ack is a single-cycle pulse, and dm_rdata is only meaningful in that
// same cycle. An ack seen while no request is pending is ignored.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        me_valid,
   input  logic        me_memRead,
   input  logic        me_memWrite,
   input  logic [1:0]  me_memSize,
   input  logic        me_memSigned,
   input  logic [31:0] me_addr,
   input  logic [31:0] me_storeData,
   input  logic        me_writeRegIn,
   output logic        dm_req,
   output logic        dm_we,
   output logic [29:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_wstrb,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [31:0] me_outMem,
   output logic        me_writeReg,
   output logic        stall,
   output logic        me_misalign,
   output logic        me_busErr,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] out_q, out_d;
   logic        bus_err_q, bus_err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        access, aligned;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Decode the access, and build the store lanes and the load-extract value.
   always_comb begin
      access  = me_valid & (me_memRead | me_memWrite);
      aligned = 1'b1;
      st_wdata = me_storeData;
      st_wstrb = 4'b1111;
      ld_data  = dm_rdata;
      ld_byte  = 8'h00;
      ld_half  = 16'h0000;
      case (me_addr[1:0])
         2'd0:    ld_byte = dm_rdata[7:0];
         2'd1:    ld_byte = dm_rdata[15:8];
         2'd2:    ld_byte = dm_rdata[23:16];
         default: ld_byte = dm_rdata[31:24];
      endcase
      ld_half = me_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (me_memSize)
         2'b00: begin
            st_wdata = {4{me_storeData[7:0]}};
            st_wstrb = 4'b0001 << me_addr[1:0];
            ld_data  = {{24{me_memSigned & ld_byte[7]}}, ld_byte};
         end
         2'b01: begin
            aligned  = ~me_addr[0];
            st_wdata = {2{me_storeData[15:0]}};
            st_wstrb = 4'b0011 << me_addr[1:0];
            ld_data  = {{16{me_memSigned & ld_half[15]}}, ld_half};
         end
         default: begin
            aligned = (me_addr[1:0] == 2'b00);
         end
      endcase
   end

   // Transaction FSM: launch from IDLE, hold in WAIT until ack or timeout,
   // then release the pipeline for one cycle in DONE.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      out_d     = out_q;
      bus_err_d = bus_err_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access & aligned) begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               we_d    = me_memWrite;
               addr_d  = me_addr[31:2];
               wdata_d = st_wdata;
               wstrb_d = st_wstrb;
               cnt_d   = 8'd0;
               stall   = 1'b1;
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (dm_ack) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               cnt_d   = 8'd0;
               if (!we_q) out_d = ld_data;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_DONE;
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               out_d     = 32'h0;
               cnt_d     = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            bus_err_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and memory-port registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 30'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         out_q     <= 32'h0;
         bus_err_q <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         out_q     <= out_d;
         bus_err_q <= bus_err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Output mapping; a faulting instruction must never write its register.
   always_comb begin
      dm_req      = req_q;
      dm_we       = we_q;
      dm_addr     = addr_q;
      dm_wdata    = wdata_q;
      dm_wstrb    = wstrb_q;
      me_outMem   = out_q;
      me_busErr   = bus_err_q;
      dbg_state   = state_q;
      me_misalign = access & ~aligned;
      me_writeReg = me_writeRegIn & ~me_misalign &
                    ~((state_q == S_DONE) & bus_err_q);
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors plus corner sequences for mem_access_unit.
module tb_mem_access_unit;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        me_valid, me_memRead, me_memWrite, me_memSigned, me_writeRegIn;
   logic [1:0]  me_memSize;
   logic [31:0] me_addr, me_storeData;
   logic        dm_req, dm_we, dm_ack;
   logic [29:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata, me_outMem;
   logic [3:0]  dm_wstrb;
   logic        me_writeReg, stall, me_misalign, me_busErr;
   logic [1:0]  dbg_state;

   int tests_run = 0;
   int failures  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        rd, wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr, sdata, rdata;
      logic        wreg, exp_we;
      logic [29:0] exp_daddr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_out;
   } vec_t;

   vec_t tbl[10];

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .me_valid(me_valid), .me_memRead(me_memRead), .me_memWrite(me_memWrite),
      .me_memSize(me_memSize), .me_memSigned(me_memSigned), .me_addr(me_addr),
      .me_storeData(me_storeData), .me_writeRegIn(me_writeRegIn),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .me_outMem(me_outMem), .me_writeReg(me_writeReg), .stall(stall),
      .me_misalign(me_misalign), .me_busErr(me_busErr), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic wreg, input logic exp_we,
                               input logic [29:0] exp_daddr, input logic [31:0] exp_wdata,
                               input logic [3:0] exp_wstrb, input logic [31:0] exp_out);
      vec_t v;
      v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
      v.sdata = sdata; v.rdata = rdata; v.wreg = wreg; v.exp_we = exp_we;
      v.exp_daddr = exp_daddr; v.exp_wdata = exp_wdata; v.exp_wstrb = exp_wstrb;
      v.exp_out = exp_out;
      return v;
   endfunction

   // driver: pipeline bubble on the ME inputs
   task automatic drive_bubble();
      me_valid = 0; me_memRead = 0; me_memWrite = 0; me_memSize = 2'b10;
      me_memSigned = 0; me_addr = 32'h0; me_storeData = 32'h0; me_writeRegIn = 0;
   endtask

   // driver: one memory instruction acked in the first WAIT cycle
   task automatic run_txn(input vec_t v);
      @(negedge clk);
      me_valid = 1; me_memRead = v.rd; me_memWrite = v.wr; me_memSize = v.size;
      me_memSigned = v.sgn; me_addr = v.addr; me_storeData = v.sdata;
      me_writeRegIn = v.wreg; dm_ack = 0;
      exp_q.push_back(v.exp_out);
      #1;
      chk("idle_stall", stall, 1);
      chk("idle_req", dm_req, 0);
      chk("idle_misalign", me_misalign, 0);
      @(negedge clk);
      chk("wait_state", dbg_state, S_WAIT);
      chk("wait_req", dm_req, 1);
      chk("wait_stall", stall, 1);
      chk("wait_we", dm_we, v.exp_we);
      chk("wait_addr", dm_addr, v.exp_daddr);
      chk("wait_wdata", dm_wdata, v.exp_wdata);
      chk("wait_wstrb", dm_wstrb, v.exp_wstrb);
      dm_ack = 1; dm_rdata = v.rdata;
      @(negedge clk);
      dm_ack = 0; dm_rdata = 32'h5A5A_A5A5;
      #1;
      chk("done_state", dbg_state, S_DONE);
      chk("done_req", dm_req, 0);
      chk("done_stall", stall, 0);
      chk("done_outmem", me_outMem, exp_q.pop_front());
      chk("done_writereg", me_writeReg, v.wreg);
      chk("done_buserr", me_busErr, 0);
      drive_bubble();
   endtask

   initial begin
      tbl[0] = mk(1,0,2'b10,0,32'h0000_0104,32'h0,32'hDEADBEEF,1,0,30'h41, 32'h0,4'b1111,32'hDEADBEEF);
      tbl[1] = mk(1,0,2'b00,1,32'h0000_1003,32'h0,32'h80112233,1,0,30'h400,32'h0,4'b1000,32'hFFFFFF80);
      tbl[2] = mk(1,0,2'b00,0,32'h0000_1003,32'h0,32'h80112233,1,0,30'h400,32'h0,4'b1000,32'h00000080);
      tbl[3] = mk(1,0,2'b01,1,32'h0000_2002,32'h0,32'h80015555,1,0,30'h800,32'h0,4'b1100,32'hFFFF8001);
      tbl[4] = mk(0,1,2'b00,0,32'h0000_3002,32'h123456AB,32'h0,0,1,30'hC00,32'hABABABAB,4'b0100,32'hFFFF8001);
      tbl[5] = mk(0,1,2'b01,0,32'h0000_3002,32'h0000BEEF,32'h0,0,1,30'hC00,32'hBEEFBEEF,4'b1100,32'hFFFF8001);
      tbl[6] = mk(1,0,2'b01,0,32'h0000_0010,32'h0,32'h1234F00D,1,0,30'h4,32'h0,4'b0011,32'h0000F00D);
      tbl[7] = mk(1,0,2'b00,0,32'h0000_0011,32'h0,32'h0000A500,1,0,30'h4,32'h0,4'b0010,32'h000000A5);
      tbl[8] = mk(1,1,2'b10,0,32'h0000_0020,32'hCAFEF00D,32'h0,0,1,30'h8,32'hCAFEF00D,4'b1111,32'h000000A5);
      tbl[9] = mk(1,0,2'b11,0,32'h0000_0024,32'h0,32'h01234567,1,0,30'h9,32'h0,4'b1111,32'h01234567);

      drive_bubble();
      dm_ack = 0; dm_rdata = 32'h0;
      rst = 0;
      #12;
      chk("rst_req", dm_req, 0);
      chk("rst_we", dm_we, 0);
      chk("rst_addr", dm_addr, 0);
      chk("rst_wdata", dm_wdata, 0);
      chk("rst_wstrb", dm_wstrb, 0);
      chk("rst_outmem", me_outMem, 0);
      chk("rst_buserr", me_busErr, 0);
      chk("rst_stall", stall, 0);
      chk("rst_state", dbg_state, S_IDLE);
      @(negedge clk);
      rst = 1;

      // table-driven single transactions
      for (int i = 0; i < 10; i++) run_txn(tbl[i]);

      // misaligned word and half: no request, no stall, no register write
      @(negedge clk);
      me_valid = 1; me_memRead = 1; me_memSize = 2'b10; me_addr = 32'h0000_0006;
      me_writeRegIn = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("mis_w_stall", stall, 0);
         chk("mis_w_flag", me_misalign, 1);
         chk("mis_w_wreg", me_writeReg, 0);
         chk("mis_w_req", dm_req, 0);
         @(negedge clk);
      end
      me_memSize = 2'b01; me_addr = 32'h0000_0001;
      #1;
      chk("mis_h_flag", me_misalign, 1);
      chk("mis_h_stall", stall, 0);
      @(negedge clk);
      chk("mis_h_req", dm_req, 0);

      // bubble carrying stale memRead must not start a request
      me_valid = 0; me_addr = 32'h0000_0040; me_memSize = 2'b10;
      #1;
      chk("bubble_stall", stall, 0);
      chk("bubble_misalign", me_misalign, 0);

      // ALU-only instructions back-to-back after a load: zero stall
      run_txn(tbl[0]);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         me_valid = 1; me_memRead = 0; me_memWrite = 0; me_writeRegIn = 1;
         me_addr = 32'h0000_0003 + 32'(c);
         #1;
         chk("alu_stall", stall, 0);
         chk("alu_misalign", me_misalign, 0);
         chk("alu_wreg", me_writeReg, 1);
         chk("alu_state", dbg_state, S_IDLE);
      end
      run_txn(tbl[3]);

      // timeout: no ack for TIMEOUT=4 WAIT cycles
      @(negedge clk);
      me_valid = 1; me_memRead = 1; me_memSize = 2'b10; me_addr = 32'h0000_0040;
      me_writeRegIn = 1;
      #1;
      chk("to_idle_stall", stall, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("to_wait_req", dm_req, 1);
         chk("to_wait_stall", stall, 1);
         chk("to_wait_addr", dm_addr, 30'h10);
      end
      @(negedge clk);
      #1;
      chk("to_done_state", dbg_state, S_DONE);
      chk("to_done_req", dm_req, 0);
      chk("to_done_buserr", me_busErr, 1);
      chk("to_done_outmem", me_outMem, 0);
      chk("to_done_stall", stall, 0);
      chk("to_done_wreg", me_writeReg, 0);
      drive_bubble();
      dm_ack = 1; dm_rdata = 32'h1111_2222;
      @(negedge clk);
      chk("to_late_state", dbg_state, S_IDLE);
      chk("to_late_buserr", me_busErr, 0);
      chk("to_late_req", dm_req, 0);
      @(negedge clk);
      dm_ack = 0;
      chk("to_late2_state", dbg_state, S_IDLE);
      chk("to_late_outmem", me_outMem, 0);

      // reset asserted while waiting abandons the transaction
      @(negedge clk);
      me_valid = 1; me_memRead = 1; me_memSize = 2'b10; me_addr = 32'h0000_0050;
      me_writeRegIn = 1;
      @(negedge clk);
      chk("rw_wait_req", dm_req, 1);
      #2;
      rst = 0;
      drive_bubble();
      #1;
      chk("rw_req", dm_req, 0);
      chk("rw_state", dbg_state, S_IDLE);
      chk("rw_stall", stall, 0);
      @(negedge clk);
      rst = 1;
      dm_ack = 1; dm_rdata = 32'h3333_4444;
      @(negedge clk);
      dm_ack = 0;
      chk("rw_late_state", dbg_state, S_IDLE);
      chk("rw_late_req", dm_req, 0);
      chk("rw_late_outmem", me_outMem, 0);

      // a normal load still works after all of that
      run_txn(tbl[9]);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
